// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
// Shares one pipelined single-precision adder among NUM_REQ requesters.
// A round-robin arbiter issues at most one operand pair per cycle. A tag
// shift register carries each issued operation's requester ID alongside the
// adder pipeline. Results land in a small FIFO that returns them in issue
// order under consumer backpressure.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   per-requester operand handshake (ready is one-hot or 0)
//   req_a/req_b       packed operands, requester i at [32i+31:32i]
//   add_enable        adder pipeline enable (= !reset)
//   add_a/add_b       operands to the adder (0/0 on bubble cycles)
//   add_result        adder sum, ADD_LATENCY cycles after operands
//   add_overflow      adder overflow flag, aligned with add_result
//   rsp_valid/ready   result handshake from the FIFO head
//   rsp_id/result/overflow  head entry contents
//   busy              any operation in flight or queued
//
// Handshake rule, both sides: a beat transfers in the cycle where valid and
// ready are both high. The head of the result FIFO is held stable while
// rsp_valid is high and rsp_ready is low.
module fp_add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   add_enable,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  input  logic [31:0]            add_result,
  input  logic                   add_overflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_overflow,
  output logic                   busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ADD_LATENCY-1:0] tag_valid_q;
  logic [IDW-1:0]         tag_id_q [ADD_LATENCY];

  logic [IDW-1:0]         fifo_id_q  [FIFO_DEPTH];
  logic [31:0]            fifo_res_q [FIFO_DEPTH];
  logic                   fifo_ovf_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;

  logic                   found;
  logic [IDW-1:0]         win;
  logic [IDW:0]           cand;
  logic [31:0]            inflight;
  logic                   issue_ok;
  logic                   transfer;
  logic                   push;
  logic                   pop;

  // Search from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < ADD_LATENCY; k++) inflight = inflight + 32'(tag_valid_q[k]);
  end

  // Credit: every issued op already owns a FIFO slot, so a push can never
  // find the FIFO full. A same-cycle pop is deliberately not counted.
  assign issue_ok  = !reset && ((32'(count_q) + inflight) < 32'(FIFO_DEPTH));
  assign transfer  = issue_ok && found;
  assign req_ready = transfer ? (NUM_REQ'(1) << win) : '0;

  assign add_enable = !reset;
  assign add_a      = transfer ? req_a[32*int'(win) +: 32] : 32'h0;
  assign add_b      = transfer ? req_b[32*int'(win) +: 32] : 32'h0;

  assign rr_ptr_d = !transfer ? rr_ptr_q :
                    (win == IDW'(NUM_REQ-1)) ? '0 : win + 1'b1;

  // The last tag stage lines up with add_result for the op it describes.
  assign push = tag_valid_q[ADD_LATENCY-1];
  assign pop  = rsp_valid && rsp_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      tag_valid_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int k = 0; k < ADD_LATENCY; k++) tag_id_q[k] <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_id_q[k]  <= '0;
        fifo_res_q[k] <= '0;
        fifo_ovf_q[k] <= 1'b0;
      end
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      tag_valid_q[0] <= transfer;
      tag_id_q[0]    <= win;
      for (int k = 1; k < ADD_LATENCY; k++) begin
        tag_valid_q[k] <= tag_valid_q[k-1];
        tag_id_q[k]    <= tag_id_q[k-1];
      end
      if (push) begin
        fifo_id_q[wr_ptr_q]  <= tag_id_q[ADD_LATENCY-1];
        fifo_res_q[wr_ptr_q] <= add_result;
        fifo_ovf_q[wr_ptr_q] <= add_overflow;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rsp_valid    = (count_q != '0);
  assign rsp_id       = fifo_id_q[rd_ptr_q];
  assign rsp_result   = fifo_res_q[rd_ptr_q];
  assign rsp_overflow = fifo_ovf_q[rd_ptr_q];
  assign busy         = (|tag_valid_q) || rsp_valid;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: a 2-stage adder stand-in, a queue-based model of
// issue order / credit / response timing, a per-cycle compare process and a
// set of directed scenarios followed by random traffic.
module tb_fp_add_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 2;
  localparam int DEPTH   = 4;
  localparam int IDW     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  add_enable;
  logic [31:0]           add_a, add_b, add_result;
  logic                  add_overflow;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_overflow;
  logic                  busy;

  fp_add_arbiter #(.NUM_REQ(NUM_REQ), .ADD_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_enable(add_enable), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_overflow(add_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .busy(busy)
  );

  // Simplified single-precision add for positive normal operands, truncating.
  function automatic logic [32:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb, mbs;
    logic [24:0] s;
    logic [8:0]  er;
    int d;
    if (a[30:23] >= b[30:23]) begin
      ea = a[30:23]; ma = {1'b1, a[22:0]}; eb = b[30:23]; mb = {1'b1, b[22:0]};
    end else begin
      ea = b[30:23]; ma = {1'b1, b[22:0]}; eb = a[30:23]; mb = {1'b1, a[22:0]};
    end
    d   = int'(ea) - int'(eb);
    mbs = (d > 23) ? 24'd0 : (mb >> d);
    s   = {1'b0, ma} + {1'b0, mbs};
    er  = {1'b0, ea};
    if (s[24]) begin
      s  = s >> 1;
      er = er + 9'd1;
    end
    if (er >= 9'd255) return {1'b1, 32'h7F800000};
    return {1'b0, 1'b0, er[7:0], s[22:0]};
  endfunction

  // Adder stand-in: operands captured for LAT cycles, result presented after.
  logic [31:0] pa0, pb0, pa1, pb1;
  always @(posedge clk) begin
    if (add_enable) begin
      pa0 <= add_a; pb0 <= add_b;
      pa1 <= pa0;   pb1 <= pb0;
    end
  end
  assign {add_overflow, add_result} = fp_model(pa1, pb1);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  logic [IDW+63:0] exp_q[$];    // {id, a, b} in issue order, issued but not popped
  int              cyc_q[$];    // issue cycle of each exp_q entry
  int              grant_log[$];
  int              xfer_cnt = 0;
  int              cyc = 0;
  int              rr_m = 0;

  int                m_w;
  bit                m_any;
  logic [NUM_REQ-1:0] m_ready;
  logic [31:0]       m_a, m_b;
  logic              m_rv;
  logic [32:0]       m_sum;
  logic [IDW+63:0]   head;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("reset_req_ready", req_ready, 0);
      chk("reset_add_enable", add_enable, 0);
      chk("reset_add_a", add_a, 0);
      chk("reset_add_b", add_b, 0);
      exp_q.delete();
      cyc_q.delete();
      rr_m = 0;
    end else begin
      m_any = 1'b0;
      m_w   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!m_any && req_valid[(rr_m + k) % NUM_REQ]) begin
          m_any = 1'b1;
          m_w   = (rr_m + k) % NUM_REQ;
        end
      end
      m_ready = (m_any && exp_q.size() < DEPTH) ? (NUM_REQ'(1) << m_w) : '0;
      m_a = (m_ready != 0) ? req_a[32*m_w +: 32] : 32'h0;
      m_b = (m_ready != 0) ? req_b[32*m_w +: 32] : 32'h0;
      m_rv = (exp_q.size() > 0) && (cyc_q[0] + LAT + 1 <= cyc);

      chk("req_ready", req_ready, m_ready);
      chk("add_enable", add_enable, 1);
      chk("add_a", add_a, m_a);
      chk("add_b", add_b, m_b);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("busy", busy, exp_q.size() != 0);
      if (m_rv) begin
        head  = exp_q[0];
        m_sum = fp_model(head[63:32], head[31:0]);
        chk("rsp_id", rsp_id, head[IDW+63:64]);
        chk("rsp_result", rsp_result, m_sum[31:0]);
        chk("rsp_overflow", rsp_overflow, m_sum[32]);
      end

      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          xfer_cnt++;
        end
      end

      if (m_rv && rsp_ready) begin
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
      if (m_ready != 0) begin
        exp_q.push_back({IDW'(m_w), m_a, m_b});
        cyc_q.push_back(cyc);
        rr_m = (m_w + 1) % NUM_REQ;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(254, 250));
    else e = 8'($urandom_range(253, 1));
    return {1'b0, e, 23'($urandom)};
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = rand_op();
      req_b[32*i +: 32] = rand_op();
    end
  endtask

  // Returns at posedge+1 with the design empty (or a FAIL line recorded).
  task automatic wait_idle();
    int n;
    req_valid = '0;
    rsp_ready = 1'b1;
    reset     = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", busy, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int base;

  initial begin
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_rsp_valid", rsp_valid, 0);
    chk("post_reset_rsp_id", rsp_id, 0);
    chk("post_reset_rsp_result", rsp_result, 0);
    chk("post_reset_rsp_overflow", rsp_overflow, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_add_a", add_a, 0);
    step();

    // Single request from requester 2: 1.0 + 2.0 = 3.0, response 3 cycles later.
    req_valid = 4'b0100;
    req_a[95:64] = 32'h3F800000;
    req_b[95:64] = 32'h40000000;
    @(negedge clk);
    chk("single_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single_t1_valid", rsp_valid, 0);
    step();
    @(negedge clk);
    chk("single_t2_valid", rsp_valid, 0);
    step();
    @(negedge clk);
    chk("single_t3_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 2);
    chk("single_result", rsp_result, 32'h40400000);
    chk("single_overflow", rsp_overflow, 0);

    // All requesters continuously valid: strict rotation starting after 2.
    wait_idle();
    base = grant_log.size();
    req_valid = '1;
    repeat (30) begin rand_ops(); step(); end
    req_valid = '0;
    chk("rr_enough_grants", (grant_log.size() - base) >= 8, 1);
    if (grant_log.size() > base) begin
      chk("rr_first", grant_log[base], 3);
      for (int k = base; k < grant_log.size() - 1; k++)
        chk("rr_rotation", grant_log[k+1], (grant_log[k] + 1) % NUM_REQ);
    end

    // Backpressure: exactly DEPTH transfers, then grants stop until drained.
    wait_idle();
    base = xfer_cnt;
    req_valid = '1;
    rsp_ready = 1'b0;
    repeat (12) begin rand_ops(); step(); end
    @(negedge clk);
    chk("bp_ready_zero", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    step();
    chk("bp_transfers", xfer_cnt - base, DEPTH);
    rsp_ready = 1'b1;
    repeat (20) begin rand_ops(); step(); end
    chk("bp_resumed", xfer_cnt - base > DEPTH, 1);
    req_valid = '0;

    // Overflow propagation from requester 1.
    wait_idle();
    req_valid = 4'b0010;
    req_a[63:32] = 32'h7F000000;
    req_b[63:32] = 32'h7F000000;
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    chk("ovf_t2_valid", rsp_valid, 0);
    step();
    @(negedge clk);
    chk("ovf_valid", rsp_valid, 1);
    chk("ovf_id", rsp_id, 1);
    chk("ovf_result", rsp_result, 32'h7F800000);
    chk("ovf_flag", rsp_overflow, 1);

    // Reset with 2 results queued and 2 in flight.
    wait_idle();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    repeat (4) begin rand_ops(); step(); end
    req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("prereset_busy", busy, 1);
    chk("prereset_rsp_valid", rsp_valid, 1);
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_busy", busy, 0);
    repeat (6) begin
      step();
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    step();
    req_valid = '1;
    rand_ops();
    @(negedge clk);
    chk("post_reset_grant0", req_ready, 4'b0001);
    step();
    req_valid = '0;

    // Push and pop in the same cycle with 3 entries queued.
    wait_idle();
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid = NUM_REQ'(1) << i;
      rand_ops();
      step();
    end
    req_valid = '0;
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("pp_head_before", rsp_id, 0);
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("pp_head_after", rsp_id, 1);
    chk("pp_valid_after", rsp_valid, 1);
    step();

    // Random traffic with random backpressure and occasional resets.
    repeat (800) begin
      req_valid = NUM_REQ'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_valid = '0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      rand_ops();
      step();
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
